id_ex_stage: RTL and testbench

//  Decode-to-execute stage of the 5-stage MIPS pipeline, directly upstream of EX and downstream of the register file.
//  - Drives the register file read addresses from the IF/ID instruction.
//  - Captures the operands, immediate and control word into the ID/EX register.
//  - Detects load-use hazards, stalling F/D and inserting an EX bubble.
//  - Keeps stall/flush performance counters.
//  - The register file writes on negedge, so WB->ID needs no bypass here. EX-stage forwarding lives in EX.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/id_ex_stage_hazard_detect.sv | 22 ++
 rtl/id_ex_stage.sv | 90 +++++++++
 tb/tb_id_ex_stage.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: control-word bit positions and instruction field offsets shared by the pipeline stages
package pipe_pkg;
  localparam int CTRL_W = 8;
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_REGDST = 2;
  localparam int CTRL_IMMSIGN = 3;
  localparam int CTRL_USES_RT = 4;
  localparam int OP_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect: load-use detection between the EX load and the instruction in ID
module hazard_detect (
  input  logic       reset,
  input  logic       flush_e,
  input  logic       valid_d,
  input  logic       valid_e,
  input  logic       memtoreg_e,
  input  logic       regwrite_e,
  input  logic       uses_rt_d,
  input  logic [4:0] write_reg_e,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  output logic       stall_f,
  output logic       stall_d
);
  logic lu;
  assign lu = valid_d & valid_e & memtoreg_e & regwrite_e & (write_reg_e != 5'd0)
            & ((write_reg_e == rs_d) | ((write_reg_e == rt_d) & uses_rt_d));
  // a redirected ID instruction is dead, so it must not hold fetch
  assign stall_f = lu & ~flush_e & ~reset;
  assign stall_d = stall_f;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: register-file addressing, ID/EX pipeline register, load-use bubbles and perf counters
module id_ex_stage #(
  parameter int CTRL_W = pipe_pkg::CTRL_W,
  parameter int CNT_W = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              ValidD,
  input  logic [31:0]       InstrD,
  input  logic [31:0]       PCPlus4D,
  input  logic [CTRL_W-1:0] CtrlD,
  input  logic              FlushE,
  output logic [4:0]        RA1,
  output logic [4:0]        RA2,
  input  logic [31:0]       RD1,
  input  logic [31:0]       RD2,
  output logic              StallF,
  output logic              StallD,
  output logic              ValidE,
  output logic [CTRL_W-1:0] CtrlE,
  output logic [31:0]       SrcAE,
  output logic [31:0]       WdE,
  output logic [31:0]       ImmE,
  output logic [4:0]        RsE,
  output logic [4:0]        RtE,
  output logic [4:0]        WriteRegE,
  output logic [31:0]       PCPlus4E,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt
);
  import pipe_pkg::*;
  logic [4:0] rs, rt, rd;
  logic unused_op;
  assign rs = InstrD[RS_LSB +: 5];
  assign rt = InstrD[RT_LSB +: 5];
  assign rd = InstrD[RD_LSB +: 5];
  assign unused_op = ^InstrD[OP_LSB +: 6];
  assign RA1 = rs;
  assign RA2 = rt;
  hazard_detect u_hazard (
    .reset(Reset),
    .flush_e(FlushE),
    .valid_d(ValidD),
    .valid_e(ValidE),
    .memtoreg_e(CtrlE[CTRL_MEMTOREG]),
    .regwrite_e(CtrlE[CTRL_REGWRITE]),
    .uses_rt_d(CtrlD[CTRL_USES_RT]),
    .write_reg_e(WriteRegE),
    .rs_d(rs),
    .rt_d(rt),
    .stall_f(StallF),
    .stall_d(StallD)
  );
  // on flush or bubble only the valid/control state is cleared; data regs hold
  always_ff @(posedge CLK) begin
    if (Reset) begin
      ValidE <= 1'b0;
      CtrlE <= '0;
      SrcAE <= '0;
      WdE <= '0;
      ImmE <= '0;
      RsE <= '0;
      RtE <= '0;
      WriteRegE <= '0;
      PCPlus4E <= '0;
    end else if (FlushE | StallD) begin
      ValidE <= 1'b0;
      CtrlE <= '0;
    end else begin
      ValidE <= ValidD;
      CtrlE <= ValidD ? CtrlD : '0;
      SrcAE <= RD1;
      WdE <= RD2;
      ImmE <= CtrlD[CTRL_IMMSIGN] ? {{16{InstrD[15]}}, InstrD[15:0]} : {16'h0, InstrD[15:0]};
      RsE <= rs;
      RtE <= rt;
      WriteRegE <= CtrlD[CTRL_REGDST] ? rd : rt;
      PCPlus4E <= PCPlus4D;
    end
  end
  always_ff @(posedge CLK) begin
    if (Reset) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      StallCnt <= StallCnt + CNT_W'(StallD & ~&StallCnt);
      FlushCnt <= FlushCnt + CNT_W'(FlushE & ValidD & ~&FlushCnt);
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: randomized and directed checks of id_ex_stage against a cycle-level pipeline model
module tb_id_ex_stage;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic Reset, ValidD, FlushE;
  logic [31:0] InstrD, PCPlus4D, RD1, RD2;
  logic [7:0] CtrlD;
  logic [4:0] RA1, RA2, RsE, RtE, WriteRegE;
  logic StallF, StallD, ValidE;
  logic [7:0] CtrlE;
  logic [31:0] SrcAE, WdE, ImmE, PCPlus4E, StallCnt, FlushCnt;
  logic [4:0] s_RA1, s_RA2, s_RsE, s_RtE, s_WriteRegE;
  logic s_StallF, s_StallD, s_ValidE;
  logic [7:0] s_CtrlE;
  logic [31:0] s_SrcAE, s_WdE, s_ImmE, s_PCPlus4E;
  logic [3:0] s_StallCnt, s_FlushCnt;

  id_ex_stage #(.CTRL_W(8), .CNT_W(32)) dut (
    .CLK(CLK), .Reset(Reset), .ValidD(ValidD), .InstrD(InstrD), .PCPlus4D(PCPlus4D),
    .CtrlD(CtrlD), .FlushE(FlushE), .RA1(RA1), .RA2(RA2), .RD1(RD1), .RD2(RD2),
    .StallF(StallF), .StallD(StallD), .ValidE(ValidE), .CtrlE(CtrlE), .SrcAE(SrcAE),
    .WdE(WdE), .ImmE(ImmE), .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE),
    .PCPlus4E(PCPlus4E), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );
  id_ex_stage #(.CTRL_W(8), .CNT_W(4)) dut_small (
    .CLK(CLK), .Reset(Reset), .ValidD(ValidD), .InstrD(InstrD), .PCPlus4D(PCPlus4D),
    .CtrlD(CtrlD), .FlushE(FlushE), .RA1(s_RA1), .RA2(s_RA2), .RD1(RD1), .RD2(RD2),
    .StallF(s_StallF), .StallD(s_StallD), .ValidE(s_ValidE), .CtrlE(s_CtrlE), .SrcAE(s_SrcAE),
    .WdE(s_WdE), .ImmE(s_ImmE), .RsE(s_RsE), .RtE(s_RtE), .WriteRegE(s_WriteRegE),
    .PCPlus4E(s_PCPlus4E), .StallCnt(s_StallCnt), .FlushCnt(s_FlushCnt)
  );

  localparam logic [7:0] LW = 8'h0B, ADD = 8'h15, ADDI = 8'h09, ORI = 8'h01;
  int checks = 0, fails = 0;

  // EX-slot model: what instruction sits in EX and what it carries
  logic m_valid;
  logic [7:0] m_ctrl;
  logic [4:0] m_rs, m_rt, m_wr;
  logic [31:0] m_srca, m_wd, m_imm, m_pc4;
  longint m_stall = 0, m_flush = 0;

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'h20};
  endfunction
  function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  // stall when EX holds a load into a nonzero register that ID reads
  function automatic bit m_hazard();
    logic [4:0] rs = InstrD[25:21], rt = InstrD[20:16];
    bit is_load = m_valid && m_ctrl[0] && m_ctrl[1];
    bit reads = (m_wr == rs) || (m_wr == rt && CtrlD[4]);
    return !Reset && !FlushE && ValidD && is_load && m_wr != 0 && reads;
  endfunction
  function automatic longint sat4(input longint v);
    return v > 15 ? 15 : v;
  endfunction

  task automatic drive(input bit v, input logic [31:0] instr, input logic [7:0] ctrl, input bit flush = 0);
    ValidD = v; InstrD = instr; CtrlD = ctrl; FlushE = flush;
    PCPlus4D = $urandom; RD1 = $urandom; RD2 = $urandom;
    #1;
  endtask

  task automatic tick();
    bit hz = m_hazard();
    @(posedge CLK);
    if (Reset) begin
      m_valid = 0; m_ctrl = 0; m_rs = 0; m_rt = 0; m_wr = 0;
      m_srca = 0; m_wd = 0; m_imm = 0; m_pc4 = 0; m_stall = 0; m_flush = 0;
    end else if (FlushE) begin
      m_valid = 0; m_ctrl = 0;
      if (ValidD) m_flush++;
    end else if (hz) begin
      m_valid = 0; m_ctrl = 0; m_stall++;
    end else begin
      m_valid = ValidD; m_ctrl = ValidD ? CtrlD : 8'h00;
      m_srca = RD1; m_wd = RD2; m_pc4 = PCPlus4D;
      m_rs = InstrD[25:21]; m_rt = InstrD[20:16];
      m_wr = CtrlD[2] ? InstrD[15:11] : InstrD[20:16];
      m_imm = CtrlD[3] ? 32'($signed(InstrD[15:0])) : 32'(InstrD[15:0]);
    end
    #1;
  endtask

  task automatic test_reset();
    Reset = 1;
    drive(1, rtype(1, 2, 3), ADD);
    tick(); tick();
    checks++; if (StallF !== 1'b0) begin fails++; $display("FAIL reset_stallf got %b exp 0", StallF); end
    tick();
    checks++; if ({ValidE, CtrlE} !== 9'h0) begin fails++; $display("FAIL reset_valid_ctrl got %b/%h exp 0/00", ValidE, CtrlE); end
    checks++; if ({StallCnt, FlushCnt} !== 64'h0) begin fails++; $display("FAIL reset_counters got %0d/%0d exp 0/0", StallCnt, FlushCnt); end
    Reset = 0;
  endtask

  task automatic test_load_use();
    drive(1, itype(6'h23, 1, 8, 0), LW);
    tick();
    drive(1, rtype(8, 2, 9), ADD);
    checks++; if ({RA1, RA2} !== {5'd8, 5'd2}) begin fails++; $display("FAIL lu_ra got %0d/%0d exp 8/2", RA1, RA2); end
    checks++; if ({StallF, StallD} !== 2'b11) begin fails++; $display("FAIL lu_stall got %b%b exp 11", StallF, StallD); end
    tick();
    checks++; if ({ValidE, CtrlE} !== 9'h0) begin fails++; $display("FAIL lu_bubble got %b/%h exp 0/00", ValidE, CtrlE); end
    checks++; if ({StallF, StallD} !== 2'b00) begin fails++; $display("FAIL lu_one_cycle got %b%b exp 00", StallF, StallD); end
    tick();
    checks++; if ({ValidE, CtrlE, RsE} !== {1'b1, ADD, 5'd8}) begin fails++; $display("FAIL lu_add_enters got %b/%h/%0d exp 1/%h/8", ValidE, CtrlE, RsE, ADD); end
    checks++; if (StallCnt !== 32'd1) begin fails++; $display("FAIL lu_stallcnt got %0d exp 1", StallCnt); end
  endtask

  task automatic test_no_stall_cases();
    drive(1, itype(6'h23, 1, 0, 4), LW);
    tick();
    drive(1, rtype(0, 0, 9), ADD);
    checks++; if (StallF !== 1'b0) begin fails++; $display("FAIL r0_no_stall got %b exp 0", StallF); end
    tick();
    drive(1, itype(6'h23, 1, 8, 4), LW);
    tick();
    drive(1, itype(6'h08, 9, 8, 1), ADDI);
    checks++; if (StallF !== 1'b0) begin fails++; $display("FAIL rt_dest_no_stall got %b exp 0", StallF); end
    tick();
    checks++; if ({ValidE, WriteRegE} !== {1'b1, 5'd8}) begin fails++; $display("FAIL rt_dest_enters got %b/%0d exp 1/8", ValidE, WriteRegE); end
  endtask

  task automatic test_reset_mid_stall();
    drive(1, itype(6'h23, 1, 8, 0), LW);
    tick();
    drive(1, rtype(8, 8, 9), ADD);
    Reset = 1; #1;
    checks++; if (StallF !== 1'b0) begin fails++; $display("FAIL reset_mid_stall_comb got %b exp 0", StallF); end
    tick();
    Reset = 0; #1;
    checks++; if ({StallF, ValidE} !== 2'b00) begin fails++; $display("FAIL reset_no_residual got %b/%b exp 0/0", StallF, ValidE); end
    tick();
    checks++; if ({ValidE, StallCnt} !== {1'b1, 32'd0}) begin fails++; $display("FAIL reset_then_issue got %b/%0d exp 1/0", ValidE, StallCnt); end
  endtask

  task automatic test_flush_on_hazard();
    Reset = 1; drive(0, 0, 0); tick(); Reset = 0;
    drive(1, itype(6'h23, 1, 8, 0), LW);
    tick();
    drive(1, rtype(8, 2, 9), ADD, 1);
    checks++; if ({StallF, StallD} !== 2'b00) begin fails++; $display("FAIL flush_stall got %b%b exp 00", StallF, StallD); end
    tick();
    checks++; if ({ValidE, CtrlE} !== 9'h0) begin fails++; $display("FAIL flush_bubble got %b/%h exp 0/00", ValidE, CtrlE); end
    checks++; if ({FlushCnt, StallCnt} !== {32'd1, 32'd0}) begin fails++; $display("FAIL flush_counters got %0d/%0d exp 1/0", FlushCnt, StallCnt); end
    drive(0, rtype(8, 2, 9), ADD, 1);
    tick();
    checks++; if (FlushCnt !== 32'd1) begin fails++; $display("FAIL flush_invalid_d got %0d exp 1", FlushCnt); end
  endtask

  task automatic test_imm_regdst();
    drive(1, itype(6'h08, 1, 2, 16'h8000), ADDI);
    tick();
    checks++; if (ImmE !== 32'hFFFF8000) begin fails++; $display("FAIL imm_sign got %h exp FFFF8000", ImmE); end
    drive(1, itype(6'h0D, 1, 2, 16'h8000), ORI);
    tick();
    checks++; if (ImmE !== 32'h00008000) begin fails++; $display("FAIL imm_zero got %h exp 00008000", ImmE); end
    drive(1, rtype(4, 5, 13), ADD);
    tick();
    checks++; if (WriteRegE !== 5'd13) begin fails++; $display("FAIL regdst got %0d exp 13", WriteRegE); end
  endtask

  task automatic test_saturation();
    Reset = 1; drive(0, 0, 0); tick(); Reset = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1, itype(6'h23, 3, 8, 0), LW);
      tick();
      drive(1, rtype(8, 8, 7), ADD);
      tick(); tick();
    end
    checks++; if (s_StallCnt !== 4'hF) begin fails++; $display("FAIL sat_small got %h exp F", s_StallCnt); end
    checks++; if (StallCnt !== 32'd20) begin fails++; $display("FAIL sat_wide got %0d exp 20", StallCnt); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] instr = $urandom;
      bit hz;
      if ($urandom_range(1, 0)) instr[25:21] = m_wr;
      if ($urandom_range(3, 0) == 0) instr[20:16] = m_wr;
      Reset = ($urandom_range(39, 0) == 0);
      drive($urandom_range(3, 0) != 0, instr, 8'($urandom), $urandom_range(7, 0) == 0);
      hz = m_hazard();
      checks++;
      if ({StallF, StallD, RA1, RA2} !== {hz, hz, instr[25:21], instr[20:16]}) begin
        fails++; $display("FAIL rnd_comb cyc %0d got %b%b %0d %0d exp %b%b %0d %0d", i, StallF, StallD, RA1, RA2, hz, hz, instr[25:21], instr[20:16]);
      end
      tick();
      checks++;
      if ({ValidE, CtrlE, StallCnt, FlushCnt, s_StallCnt} !== {m_valid, m_ctrl, 32'(m_stall), 32'(m_flush), 4'(sat4(m_stall))}) begin
        fails++; $display("FAIL rnd_state cyc %0d got %b %h %0d %0d %0d exp %b %h %0d %0d %0d", i, ValidE, CtrlE, StallCnt, FlushCnt, s_StallCnt, m_valid, m_ctrl, m_stall, m_flush, sat4(m_stall));
      end
      if (m_valid) begin
        checks++;
        if ({SrcAE, WdE, ImmE, RsE, RtE, WriteRegE, PCPlus4E} !== {m_srca, m_wd, m_imm, m_rs, m_rt, m_wr, m_pc4}) begin
          fails++; $display("FAIL rnd_data cyc %0d got %h %h %h %0d %0d %0d %h exp %h %h %h %0d %0d %0d %h", i, SrcAE, WdE, ImmE, RsE, RtE, WriteRegE, PCPlus4E, m_srca, m_wd, m_imm, m_rs, m_rt, m_wr, m_pc4);
        end
      end
    end
    Reset = 0;
  endtask

  initial begin
    Reset = 1; ValidD = 0; FlushE = 0; InstrD = 0; CtrlD = 0; PCPlus4D = 0; RD1 = 0; RD2 = 0;
    m_valid = 0; m_ctrl = 0; m_rs = 0; m_rt = 0; m_wr = 0; m_srca = 0; m_wd = 0; m_imm = 0; m_pc4 = 0;
    @(negedge CLK);
    test_reset();
    test_load_use();
    test_no_stall_cases();
    test_reset_mid_stall();
    test_flush_on_hazard();
    test_imm_regdst();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
